systolic_gemm_scheduler: RTL

SYSTOLIC_GEMM_SCHEDULER -- requirements
Module: systolic_gemm_scheduler

---
 rtl/transformer_pkg.sv | 17 +
 rtl/systolic_gemm_scheduler_rr_arbiter.sv | 30 +++
 rtl/systolic_gemm_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/transformer_pkg.sv
// Shared types and default geometry for the transformer GEMM scheduling blocks.
package transformer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ISSUE,
    S_DRAIN,
    S_ADV,
    S_DONE
  } state_t;

  localparam int DEF_PEX   = 2;
  localparam int DEF_PEY   = 2;
  localparam int DEF_DIM_W = 8;

endpackage

// File: rtl/systolic_gemm_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after 'start' wins.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] start,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(start) + i) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/systolic_gemm_scheduler.sv
// Arbitrates GEMM jobs onto one PEX x PEY systolic tile and walks the output
// tiles row-major, issuing one K-step beat per handshake and draining per tile.
module systolic_gemm_scheduler
  import transformer_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PEX   = DEF_PEX,
  parameter int PEY   = DEF_PEY,
  parameter int DIM_W = DEF_DIM_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0][DIM_W-1:0]  req_m,
  input  logic [NREQ-1:0][DIM_W-1:0]  req_n,
  input  logic [NREQ-1:0][DIM_W-1:0]  req_k,
  output logic [NREQ-1:0]             gnt,
  output logic                        tile_valid,
  input  logic                        tile_ready,
  output logic [DIM_W-1:0]            tile_row,
  output logic [DIM_W-1:0]            tile_col,
  output logic [DIM_W-1:0]            tile_k,
  output logic                        tile_first,
  output logic                        tile_last,
  output logic [PEX-1:0]              row_mask,
  output logic [PEY-1:0]              col_mask,
  output logic                        drain_req,
  input  logic                        drain_ack,
  output logic [NREQ-1:0]             job_done,
  output logic                        job_err,
  output logic                        busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int W1    = DIM_W + 1;

  state_t state, state_nx;

  logic             arb_lat;
  logic [NREQ-1:0]  gnt_q;
  logic [PTR_W-1:0] ptr_q;
  logic [DIM_W-1:0] m_q, n_q, k_q;
  logic [DIM_W-1:0] row_q, col_q, kidx_q;

  logic [NREQ-1:0]  arb_gnt;
  logic [PTR_W-1:0] arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (req),
    .start (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // One bit of headroom so base + PE offsets compare against M/N/K without wrapping.
  logic [W1-1:0] k_nx, row_nx, col_nx;
  logic          dims_zero, last_beat, col_wrap, row_end, hs;

  assign k_nx      = {1'b0, kidx_q} + W1'(1);
  assign row_nx    = {1'b0, row_q} + W1'(PEX);
  assign col_nx    = {1'b0, col_q} + W1'(PEY);
  assign dims_zero = (m_q == '0) || (n_q == '0) || (k_q == '0);
  assign last_beat = (k_nx == {1'b0, k_q});
  assign col_wrap  = (col_nx >= {1'b0, n_q});
  assign row_end   = (row_nx >= {1'b0, m_q});
  assign hs        = (state == S_ISSUE) && tile_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = (state != S_IDLE);
    tile_valid = (state == S_ISSUE);
    drain_req  = (state == S_DRAIN);
    tile_first = (state == S_ISSUE) && (kidx_q == '0);
    tile_last  = (state == S_ISSUE) && last_beat;
    job_done   = (state == S_DONE) ? gnt_q : '0;
    job_err    = (state == S_DONE) && dims_zero;
    gnt        = gnt_q;
    tile_row   = row_q;
    tile_col   = col_q;
    tile_k     = kidx_q;
    case (state)
      S_IDLE:  if (|req) state_nx = S_ARB;
      // First ARB cycle latches the winner; the second decides on the latched dims.
      S_ARB: begin
        if (!arb_lat) begin
          if (!arb_any) state_nx = S_IDLE;
        end else begin
          state_nx = dims_zero ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: if (hs && last_beat) state_nx = S_DRAIN;
      S_DRAIN: if (drain_ack) state_nx = S_ADV;
      S_ADV:   state_nx = (col_wrap && row_end) ? S_DONE : S_ISSUE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    row_mask = '0;
    col_mask = '0;
    for (int i = 0; i < PEX; i++)
      row_mask[i] = (({1'b0, row_q} + W1'(i)) < {1'b0, m_q});
    for (int i = 0; i < PEY; i++)
      col_mask[i] = (({1'b0, col_q} + W1'(i)) < {1'b0, n_q});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arb_lat <= 1'b0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      kidx_q  <= '0;
    end else begin
      arb_lat <= (state == S_ARB) && !arb_lat && arb_any;
      case (state)
        S_ARB: begin
          if (!arb_lat && arb_any) begin
            gnt_q  <= arb_gnt;
            m_q    <= req_m[arb_idx];
            n_q    <= req_n[arb_idx];
            k_q    <= req_k[arb_idx];
            ptr_q  <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
            row_q  <= '0;
            col_q  <= '0;
            kidx_q <= '0;
          end
        end
        S_ISSUE: if (hs && !last_beat) kidx_q <= k_nx[DIM_W-1:0];
        S_ADV: begin
          kidx_q <= '0;
          if (col_wrap) begin
            col_q <= '0;
            if (!row_end) row_q <= row_nx[DIM_W-1:0];
          end else begin
            col_q <= col_nx[DIM_W-1:0];
          end
        end
        S_DONE:  gnt_q <= '0;
        default: ;
      endcase
    end
  end

endmodule
